// File: rtl/icache_memory_responder.sv
// ---------------------------------------------------------------------------
// icache_memory_responder
//
// Main-memory side of the instruction-cache miss interface. A line-fill
// request is accepted from IDLE, the block waits MEM_LATENCY cycles, then
// returns the whole cache line as a one-cycle response pulse. A one-cycle
// turnaround follows so the icache's lingering miss indication is not taken
// as a new request. A separate line-write port fills the backing store.
//
// Handshake: req_valid_miss is a level request held by the icache until it is
// served; it is sampled only in IDLE. rsp_valid_miss is a single-cycle pulse
// and rsp_data_miss is meaningful while it is high (the value is held until
// the next load). wr_valid writes one line per cycle, in any state.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   req_addr_miss    byte address of the missing line
//   req_valid_miss   level miss request
//   rsp_data_miss    returned line data
//   rsp_valid_miss   one-cycle response pulse
//   mem_busy         high from the acceptance cycle through the turnaround
//   wr_valid         line write enable
//   wr_addr          byte address of the line to write
//   wr_data          line data to write
//   debug_state      current FSM state (IDLE=0, WAIT=1, RESP=2, TURN=3)
// ---------------------------------------------------------------------------
module icache_memory_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int LINE_WIDTH      = 128,
    parameter int MEM_LATENCY     = 10,
    parameter int MEM_DEPTH_LINES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] req_addr_miss,
    input  logic                  req_valid_miss,
    output logic [LINE_WIDTH-1:0] rsp_data_miss,
    output logic                  rsp_valid_miss,
    output logic                  mem_busy,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LINE_WIDTH-1:0] wr_data,
    output logic [1:0]            debug_state
);

    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int INDEX_BITS  = $clog2(MEM_DEPTH_LINES);
    localparam int INDEX_TOP   = OFFSET_BITS + INDEX_BITS;
    // Counter only has to hold MEM_LATENCY-1.
    localparam int CNT_BITS    = $clog2(MEM_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t                state;
    logic [CNT_BITS-1:0]   count;
    logic [INDEX_BITS-1:0] pend_idx;
    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [LINE_WIDTH-1:0] store [MEM_DEPTH_LINES];

    // Upper address bits alias and byte-offset bits are don't-care.
    assign req_idx = req_addr_miss[INDEX_TOP-1:OFFSET_BITS];
    assign wr_idx  = wr_addr[INDEX_TOP-1:OFFSET_BITS];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_miss[ADDR_WIDTH-1:INDEX_TOP],
                                req_addr_miss[OFFSET_BITS-1:0],
                                wr_addr[ADDR_WIDTH-1:INDEX_TOP],
                                wr_addr[OFFSET_BITS-1:0]};

    // Backing store: never reset, writes honoured even while reset is high.
    always_ff @(posedge clock) begin
        if (wr_valid) begin
            store[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            pend_idx       <= '0;
            rsp_valid_miss <= 1'b0;
            rsp_data_miss  <= '0;
        end else begin
            rsp_valid_miss <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_miss) begin
                        pend_idx <= req_idx;
                        count    <= CNT_BITS'(MEM_LATENCY - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    count <= count - 1'b1;
                    if (count == CNT_BITS'(1)) begin
                        state          <= RESP;
                        rsp_valid_miss <= 1'b1;
                        // A write to the pending line on the load edge wins.
                        if (wr_valid && (wr_idx == pend_idx)) begin
                            rsp_data_miss <= wr_data;
                        end else begin
                            rsp_data_miss <= store[pend_idx];
                        end
                    end
                end
                RESP: state <= TURN;
                TURN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Busy must already be high in the acceptance cycle itself, so it is
    // decoded from the state plus the live request rather than registered.
    assign mem_busy    = !reset && ((state != IDLE) || req_valid_miss);
    assign debug_state = state;

endmodule

// File: doc/icache_memory_responder.md
Name: icache_memory_responder

Overview:
- Main-memory side of the instruction-cache miss interface.
- Accepts line-fill requests from the instruction cache and waits a fixed memory latency.
- Returns one full cache line from a line-organised backing store as a one-cycle response pulse.
- Also has a line-write port so the program loader (and, later, the data-cache eviction path) can fill the store.

Parameters:
- ADDR_WIDTH, 32, byte address width; matches `ICACHE_ADDR_WIDTH.
- LINE_WIDTH, 128, line width in bits; matches `ICACHE_LINE_WIDTH; must be a power of two and ≥ 8.
- MEM_LATENCY, 10, cycles from request acceptance to response; matches `MAIN_MEMORY_LATENCY; legal range ≥ 2.
- MEM_DEPTH_LINES, 1024, number of lines in the backing store; power of two.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_addr_miss  in  ADDR_WIDTH  byte address of the missing line (from the icache).
- req_valid_miss  in  1  level request; the icache holds it high while it has a miss.
- rsp_data_miss  out  LINE_WIDTH  line data; valid only when rsp_valid_miss is 1.
- rsp_valid_miss  out  1  one-cycle response pulse.
- mem_busy  out  1  high from the acceptance cycle through the turnaround cycle.
- wr_valid  in  1  line write enable.
- wr_addr  in  ADDR_WIDTH  byte address of the line to write.
- wr_data  in  LINE_WIDTH  line data to write.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports named clock, reset).
- Reset values: rsp_valid_miss=0, rsp_data_miss=0, mem_busy=0, FSM=IDLE, latency counter=0, captured address=0. The backing store is not reset.
- Line index: addr[log2(LINE_WIDTH/8) + log2(MEM_DEPTH_LINES) - 1 : log2(LINE_WIDTH/8)]. Upper bits are ignored (aliasing wrap) and byte-offset bits are ignored.
- FSM states: IDLE, WAIT, RESP, TURN.
- IDLE:
  - If req_valid_miss=1, capture the line index, load counter = MEM_LATENCY-1, set mem_busy=1, go to WAIT.
  - The acceptance cycle is cycle 0.
- WAIT:
  - req_valid_miss and req_addr_miss are ignored.
  - Counter decrements each cycle.
  - When counter = 1, the next edge reads the store into the rsp_data_miss register and moves to RESP.
  - Net effect: RESP occupies cycle MEM_LATENCY.
- RESP:
  - rsp_valid_miss=1 for exactly one cycle; rsp_data_miss holds the line.
  - Next state is TURN.
- TURN:
  - One cycle; rsp_valid_miss=0 and req_valid_miss is ignored.
  - This absorbs the icache's combinational miss indication, which is still asserted in the cycle after the fill.
  - Next state is IDLE.
  - Back-to-back misses are therefore accepted no earlier than MEM_LATENCY+2 cycles after the previous acceptance.
- Response data: rsp_data_miss holds its value after RESP and changes only on the next load.
- Only one request is outstanding; there is no queue. A request arriving while busy is not lost, because the icache keeps req_valid_miss high until it is served.
- Writes:
  - Accepted every cycle in any state (independent of the FSM); store[index(wr_addr)] = wr_data at the edge.
  - Write/read collision: if wr_valid=1 to the pending line on the same edge that loads rsp_data_miss, rsp_data_miss = wr_data (write-first forwarding).
  - Writes on earlier edges are visible through the store.
  - Writes after the load edge do not alter the response already registered.
- Reset mid-operation: the FSM returns to IDLE and any pending response is cancelled (no rsp_valid_miss pulse). A write presented in the reset cycle is still performed.
- A request presented in the reset cycle is not accepted. It is accepted in the first cycle after reset if still held.

Test Plan:
- Preload line 0x10 (wr_addr=0x100) with 0xDEADBEEF_00000001_00000002_00000003; req 0x104 held high at cycle 0 -> rsp_valid_miss=1 only in cycle 10 with that data; mem_busy=1 in cycles 0–11; the next request is accepted in cycle 12.
- Requester holds req_valid_miss through the response and turnaround -> exactly one rsp_valid_miss pulse; no second acceptance before cycle 12.
- Write line 0x10 with 0xAAAA…AA on the load edge (end of cycle 9) of a pending read of 0x100 -> response data = 0xAAAA…AA. The same write one edge later -> response = the old value, and the store holds 0xAAAA…AA.
- Assert reset in cycle 5 of a pending request -> rsp_valid_miss stays 0; mem_busy=0 after the edge; a re-issued request returns its response MEM_LATENCY cycles after re-acceptance.
- Aliasing: write to address 0x100 + MEM_DEPTH_LINES*16 = 0x4100 then read 0x100 -> returns the written data.
- MEM_LATENCY=2 build: request at cycle 0 -> response in cycle 2; next acceptance in cycle 4.
